// File: rtl/byte_unstriping_n_pkg.sv
// Shared definitions for the byte un-striper and the future striper:
// FSM state encoding and the lane-count clamp helper.
package byte_unstriping_n_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam int MIN_LANES = 1;

  // Clamp a requested lane count into MIN_LANES..max_lanes.
  function automatic int clamp_lanes(input int cfg, input int max_lanes);
    if (cfg < MIN_LANES) return MIN_LANES;
    if (cfg > max_lanes) return max_lanes;
    return cfg;
  endfunction

endpackage

// File: rtl/byte_unstriping_n_sync_fifo.sv
// Single-clock first-word-fall-through FIFO used as a per-lane deskew buffer.
// Ports: clk, reset (async high), push/din, pop/dout, full, empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_wr_en;
  logic             w_rd_en;

  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[AW] != r_rd[AW]) &&
                 (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign dout  = r_mem[r_rd[AW-1:0]];

  // A push into a full FIFO is still taken when a pop frees a slot.
  assign w_rd_en = pop && !empty;
  assign w_wr_en = push && (!full || w_rd_en);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_rd_en) r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/byte_unstriping_n.sv
// Byte un-striper: rebuilds a word stream from NUM_LANES lanes in round-robin
// order with per-lane deskew FIFOs. Ports: clk, reset, cfg_lanes, lane_data,
// lane_valid, lane_ready, data_out/valid_out/out_ready, overflow_err (sticky).
module byte_unstriping_n
  import byte_unstriping_n_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LANE_W     = $clog2(NUM_LANES + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [LANE_W-1:0]               cfg_lanes,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
  input  logic [NUM_LANES-1:0]            lane_valid,
  output logic [NUM_LANES-1:0]            lane_ready,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            valid_out,
  input  logic                            out_ready,
  output logic [NUM_LANES-1:0]            overflow_err
);

  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PTR_W-1:0]      r_ptr;
  logic [LANE_W-1:0]     r_act;
  logic [LANE_W-1:0]     w_cfg_act;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic [NUM_LANES-1:0]  r_err;

  logic [NUM_LANES-1:0]  w_active;
  logic [NUM_LANES-1:0]  w_full;
  logic [NUM_LANES-1:0]  w_empty;
  logic [NUM_LANES-1:0]  w_push;
  logic [NUM_LANES-1:0]  w_pop;
  logic [NUM_LANES-1:0]  w_ovf;
  logic [DATA_WIDTH-1:0] w_dout [NUM_LANES];

  logic w_can_pop;
  logic w_take;
  logic w_all_empty;
  logic w_all_ready;
  logic w_last;

  assign w_cfg_act = LANE_W'(clamp_lanes(int'(cfg_lanes), NUM_LANES));

  // Every lane counts as active while idle so a new stream can land anywhere.
  always_comb begin
    w_active = '0;
    for (int i = 0; i < NUM_LANES; i++)
      w_active[i] = (r_state == S_IDLE) || (LANE_W'(i) < r_act);
  end

  assign w_push      = lane_valid & w_active;
  assign w_ovf       = w_push & w_full & ~w_pop;
  assign lane_ready  = w_active & ~w_full;
  assign w_all_empty = &(w_empty | ~w_active);
  assign w_all_ready = &(~w_empty | ~w_active);
  assign w_can_pop   = !r_valid || out_ready;
  assign w_last      = (LANE_W'(r_ptr) == r_act - LANE_W'(1));

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push[g]),
      .din   (lane_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .pop   (w_pop[g]),
      .dout  (w_dout[g]),
      .full  (w_full[g]),
      .empty (w_empty[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_pop       = '0;
    unique case (r_state)
      S_IDLE: begin
        if (|lane_valid) w_state_nxt = S_ALIGN;
      end
      S_ALIGN: begin
        if (w_all_ready) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_can_pop && !w_empty[r_ptr]) begin
          w_take       = 1'b1;
          w_pop[r_ptr] = 1'b1;
        end else if (w_can_pop && w_all_empty &&
                     r_ptr == '0 && lane_valid == '0) begin
          // Only leave on a round boundary so order survives a restart.
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_act   <= LANE_W'(NUM_LANES);
      r_err   <= '0;
    end else begin
      r_err <= r_err | w_ovf;
      if (r_state == S_IDLE && w_state_nxt == S_ALIGN)
        r_act <= w_cfg_act;
      if (r_state != S_RUN) begin
        r_valid <= 1'b0;
        r_ptr   <= '0;
      end else if (w_take) begin
        r_data  <= w_dout[r_ptr];
        r_valid <= 1'b1;
        r_ptr   <= w_last ? '0 : r_ptr + PTR_W'(1);
      end else if (w_can_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out     = r_data;
  assign valid_out    = r_valid;
  assign overflow_err = r_err;

endmodule
